// File: rtl/diff_capture_fifo.sv
// Capture FIFO behind the 6-bit subtractor: buffers {OF_D, diff} results and counts overflow events.
// Optional build macro DIFF_CAPTURE_DROP_OVF_EN: overflowed results are counted but not stored.
module diff_capture_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         diff,
  input  logic                     OF_D,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_diff,
  output logic                     out_of,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH:0]    mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic              push, pop, store;

  assign in_ready  = !full_q;
  assign out_valid = !empty_q;
  assign level     = level_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign ovf_count = ovf_q;

  // Next-state for pointers, occupancy, flags and the saturating overflow counter
  always_comb begin
    push = in_valid && !full_q;
    pop  = !empty_q && out_ready;
`ifdef DIFF_CAPTURE_DROP_OVF_EN
    store = push && !OF_D;
`else
    store = push;
`endif
    if (store) wr_ptr_d = wr_ptr_q + AW'(1);
    else       wr_ptr_d = wr_ptr_q;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    else     rd_ptr_d = rd_ptr_q;
    case ({store, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == LW'(0));
    if (push && OF_D && (ovf_q != {CNT_W{1'b1}})) ovf_d = ovf_q + CNT_W'(1);
    else                                          ovf_d = ovf_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is deliberately not reset; writes are gated off while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && store) mem[wr_ptr_q] <= {OF_D, diff};
  end

  // First-word fall-through head, forced to zero when nothing is stored
  always_comb begin
    if (empty_q) begin
      out_of   = 1'b0;
      out_diff = {WIDTH{1'b0}};
    end else begin
      out_of   = mem[rd_ptr_q][WIDTH];
      out_diff = mem[rd_ptr_q][WIDTH-1:0];
    end
  end

endmodule
